// File: rtl/pipeline_skid_buffer.sv
// rtl/pipeline_skid_buffer.sv - two-entry valid/ready slice with registered ready path
// Optional stall counter: define PIPELINE_SKID_BUFFER_STALL_CNT_EN to build it.
module pipeline_skid_buffer #(
    parameter int ELEM_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  clear_i,
    input  logic [ELEM_WIDTH-1:0] elem_in_i,
    input  logic                  elem_in_valid_i,
    output logic                  elem_in_ready_o,
    output logic [ELEM_WIDTH-1:0] elem_out_o,
    output logic                  elem_out_valid_o,
    input  logic                  elem_out_ready_i,
    output logic [1:0]            count_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e                state_q;
    logic [ELEM_WIDTH-1:0] main_q;
    logic [ELEM_WIDTH-1:0] skid_q;
    logic                  in_hs;
    logic                  out_hs;

    // Handshake signals are decoded from the state flop only, so ready never
    // sees elem_out_ready_i combinationally.
    assign elem_in_ready_o  = (state_q != ST_FULL);
    assign elem_out_valid_o = (state_q != ST_EMPTY);
    assign elem_out_o       = main_q;
    assign count_o          = state_q;

    assign in_hs  = elem_in_valid_i & elem_in_ready_o;
    assign out_hs = elem_out_valid_o & elem_out_ready_i;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= ST_EMPTY;
        end else if (clear_i) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_hs) state_q <= ST_BUSY;
                ST_BUSY: begin
                    if (in_hs && !out_hs)      state_q <= ST_FULL;
                    else if (out_hs && !in_hs) state_q <= ST_EMPTY;
                end
                ST_FULL:  if (out_hs) state_q <= ST_BUSY;
                default:  state_q <= ST_EMPTY;
            endcase
        end
    end

    // Data registers carry no reset; occupancy alone says what is meaningful.
    always_ff @(posedge clk_i) begin
        case (state_q)
            ST_EMPTY: if (in_hs) main_q <= elem_in_i;
            ST_BUSY: begin
                if (in_hs && out_hs) main_q <= elem_in_i;
                else if (in_hs)      skid_q <= elem_in_i;
            end
            ST_FULL:  if (out_hs) main_q <= skid_q;
            default: ;
        endcase
    end

`ifdef PIPELINE_SKID_BUFFER_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            stall_q <= '0;
        end else if (clear_i) begin
            stall_q <= '0;
        end else if (elem_out_valid_o && !elem_out_ready_i && (stall_q != {CNT_WIDTH{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_skid_buffer.sv
// tb/tb_pipeline_skid_buffer.sv - directed and scoreboarded checks for pipeline_skid_buffer
module tb_pipeline_skid_buffer;

    localparam int EW = 8;
    localparam int CW = 2;
    localparam int N_ELEMS = 10000;

    logic          clk_i = 1'b0;
    logic          arst_ni;
    logic          clear_i;
    logic [EW-1:0] elem_in_i;
    logic          elem_in_valid_i;
    logic          elem_in_ready_o;
    logic [EW-1:0] elem_out_o;
    logic          elem_out_valid_o;
    logic          elem_out_ready_i;
    logic [1:0]    count_o;
    logic [CW-1:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    pipeline_skid_buffer #(.ELEM_WIDTH(EW), .CNT_WIDTH(CW)) dut (
        .clk_i            (clk_i),
        .arst_ni          (arst_ni),
        .clear_i          (clear_i),
        .elem_in_i        (elem_in_i),
        .elem_in_valid_i  (elem_in_valid_i),
        .elem_in_ready_o  (elem_in_ready_o),
        .elem_out_o       (elem_out_o),
        .elem_out_valid_o (elem_out_valid_o),
        .elem_out_ready_i (elem_out_ready_i),
        .count_o          (count_o),
        .stall_cnt_o      (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [EW-1:0] sb[$];
        logic [EW-1:0] exp_d;
        logic [EW-1:0] prev_out;
        logic          prev_stall;
        logic          rdy_before;
        int            sent;
        int            rcvd;
        int            cyc;
        logic [CW-1:0] exp_stall [5];

`ifdef PIPELINE_SKID_BUFFER_STALL_CNT_EN
        exp_stall = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
        exp_stall = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif

        arst_ni = 1'b0;
        clear_i = 1'b0;
        elem_in_i = '0;
        elem_in_valid_i = 1'b0;
        elem_out_ready_i = 1'b0;
        #12;
        chk("rst_ready", 32'(elem_in_ready_o), 32'd1);
        chk("rst_valid", 32'(elem_out_valid_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_stall", 32'(stall_cnt_o), 32'd0);
        @(negedge clk_i);
        arst_ni = 1'b1;
        tick();
        chk("idle_count", 32'(count_o), 32'd0);

        // Full-rate stream
        elem_out_ready_i = 1'b1;
        elem_in_valid_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            elem_in_i = EW'(i);
            tick();
            chk("stream_data", 32'(elem_out_o), 32'(i));
            chk("stream_valid", 32'(elem_out_valid_o), 32'd1);
            chk("stream_count", 32'(count_o), 32'd1);
            chk("stream_ready", 32'(elem_in_ready_o), 32'd1);
        end
        elem_in_valid_i = 1'b0;
        tick();
        chk("stream_drain", 32'(count_o), 32'd0);

        // Backpressure into skid
        elem_out_ready_i = 1'b0;
        elem_in_valid_i = 1'b1;
        elem_in_i = 8'hA1;
        tick();
        chk("bp_count1", 32'(count_o), 32'd1);
        chk("bp_out1", 32'(elem_out_o), 32'hA1);
        chk("bp_ready1", 32'(elem_in_ready_o), 32'd1);
        elem_in_i = 8'hA2;
        tick();
        chk("bp_count2", 32'(count_o), 32'd2);
        chk("bp_ready2", 32'(elem_in_ready_o), 32'd0);
        chk("bp_out2", 32'(elem_out_o), 32'hA1);
        elem_in_valid_i = 1'b0;
        tick();
        chk("bp_hold", 32'(elem_out_o), 32'hA1);
        elem_out_ready_i = 1'b1;
        #1;
        chk("bp_ready_comb", 32'(elem_in_ready_o), 32'd0);
        tick();
        chk("bp_out_a2", 32'(elem_out_o), 32'hA2);
        chk("bp_recover", 32'(elem_in_ready_o), 32'd1);
        chk("bp_count3", 32'(count_o), 32'd1);
        tick();
        chk("bp_empty", 32'(elem_out_valid_o), 32'd0);

        // Flush from FULL while a new element is offered
        elem_out_ready_i = 1'b0;
        elem_in_valid_i = 1'b1;
        elem_in_i = 8'h11;
        tick();
        elem_in_i = 8'h22;
        tick();
        chk("clr_full", 32'(count_o), 32'd2);
        elem_in_i = 8'h33;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        elem_in_valid_i = 1'b0;
        chk("clr_count", 32'(count_o), 32'd0);
        chk("clr_valid", 32'(elem_out_valid_o), 32'd0);
        chk("clr_ready", 32'(elem_in_ready_o), 32'd1);
        chk("clr_stall", 32'(stall_cnt_o), 32'd0);
        elem_out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("clr_no33", 32'(elem_out_valid_o), 32'd0);
        end

        // Stall counter saturation
        elem_out_ready_i = 1'b0;
        elem_in_valid_i = 1'b1;
        elem_in_i = 8'h44;
        tick();
        elem_in_valid_i = 1'b0;
        chk("stall_start", 32'(stall_cnt_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_cnt", 32'(stall_cnt_o), 32'(exp_stall[i]));
        end
        chk("stall_data", 32'(elem_out_o), 32'h44);
        elem_out_ready_i = 1'b1;
        tick();
        chk("stall_drain", 32'(count_o), 32'd0);

        // Asynchronous reset mid-operation
        elem_out_ready_i = 1'b0;
        elem_in_valid_i = 1'b1;
        elem_in_i = 8'h55;
        tick();
        elem_in_valid_i = 1'b0;
        chk("arst_pre", 32'(count_o), 32'd1);
        #2;
        arst_ni = 1'b0;
        #1;
        chk("arst_count", 32'(count_o), 32'd0);
        chk("arst_valid", 32'(elem_out_valid_o), 32'd0);
        chk("arst_stall", 32'(stall_cnt_o), 32'd0);
        @(negedge clk_i);
        arst_ni = 1'b1;
        tick();

        // Random traffic against a queue scoreboard
        sent = 0;
        rcvd = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_out = '0;
        while (rcvd < N_ELEMS && cyc < 60000) begin
            elem_in_valid_i = (sent < N_ELEMS) && ($urandom_range(0, 9) < 7);
            elem_in_i = EW'($urandom);
            elem_out_ready_i = ($urandom_range(0, 9) < 6);
            @(negedge clk_i);
            if (prev_stall) begin
                chk("rnd_stable", 32'(elem_out_o), 32'(prev_out));
            end
            if ((cyc % 16) == 0) begin
                rdy_before = elem_in_ready_o;
                elem_out_ready_i = ~elem_out_ready_i;
                #1;
                chk("rnd_no_comb", 32'(elem_in_ready_o), 32'(rdy_before));
                elem_out_ready_i = ~elem_out_ready_i;
                #1;
            end
            if (elem_in_valid_i && elem_in_ready_o) begin
                sb.push_back(elem_in_i);
                sent++;
            end
            if (elem_out_valid_o && elem_out_ready_i) begin
                if (sb.size() == 0) begin
                    chk("rnd_spurious", 32'(elem_out_o), 32'hFFFF_FFFF);
                end else begin
                    exp_d = sb.pop_front();
                    chk("rnd_data", 32'(elem_out_o), 32'(exp_d));
                end
                rcvd++;
            end
            prev_stall = elem_out_valid_o && !elem_out_ready_i;
            prev_out = elem_out_o;
            tick();
            cyc++;
        end
        chk("rnd_all_received", 32'(rcvd), 32'(N_ELEMS));
        chk("rnd_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
